// File: rtl/acq_state_ctrl_if.sv
// Acquisition sequencer control/status bundle: capture commands in, RAM write port and status out.
// Latency: pure wiring, no storage.
// Backpressure: none; sample_valid is a strobe and the RAM write port always accepts.
interface acq_state_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              arm;
    logic              abort;
    logic              single_mode;
    logic [ADDR_W-1:0] pre_count;
    logic              sample_valid;
    logic              trig_hit;
    logic              readout_done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] trig_addr;
    logic              capture_done;
    logic              auto_trig;
    logic [7:0]        state;
    logic              state_change;

    // Host / ADC side: issues commands and samples, observes status.
    modport master (
        output arm, abort, single_mode, pre_count, sample_valid, trig_hit, readout_done,
        input  wr_en, wr_addr, trig_addr, capture_done, auto_trig, state, state_change
    );

    // Sequencer side.
    modport slave (
        input  arm, abort, single_mode, pre_count, sample_valid, trig_hit, readout_done,
        output wr_en, wr_addr, trig_addr, capture_done, auto_trig, state, state_change
    );
endinterface

// File: rtl/acq_state_ctrl.sv
// Scope acquisition sequencer: arm -> pre-trigger fill -> wait trigger -> post-trigger fill -> hold.
// Latency: state/state_change/addresses registered (1 cycle); wr_en is combinational from sample_valid.
// Backpressure: none; every sample_valid in an active state is written. Optional AUTO_TRIG_EN adds timeout trigger.
module acq_state_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int AUTO_TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    acq_state_ctrl_if.slave  bus
);
    localparam logic [7:0] S_IDLE      = 8'h00;
    localparam logic [7:0] S_PRETRIG   = 8'h01;
    localparam logic [7:0] S_WAIT_TRIG = 8'h02;
    localparam logic [7:0] S_POSTTRIG  = 8'h03;
    localparam logic [7:0] S_DONE      = 8'h04;

    // DEPTH needs one extra bit: post ranges 1..DEPTH when pre ranges 0..DEPTH-1.
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    logic [7:0]        state_q, state_d;
    logic              state_change_q, state_change_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              auto_trig_q, auto_trig_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [ADDR_W:0]   post_q, post_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   cnt_inc;
    logic              wr_en;
    logic              auto_fire;
    logic              trigger;

`ifdef AUTO_TRIG_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_hit;

    assign timeout_hit = (to_cnt_q >= TO_W'(AUTO_TIMEOUT));
    assign auto_fire   = timeout_hit;

    // Timeout counter: zero outside WAIT_TRIG, so it starts from 0 on every entry; saturates at the limit.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q != S_WAIT_TRIG) begin
            to_cnt_d = '0;
        end else if (!timeout_hit) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    // No timeout trigger in this build; the parameter only keeps the instance interface uniform.
    assign auto_fire = (AUTO_TIMEOUT < 0);
`endif

    assign wr_en   = bus.sample_valid &&
                     (state_q == S_PRETRIG || state_q == S_WAIT_TRIG || state_q == S_POSTTRIG);
    assign cnt_inc = cnt_q + ONE_C;
    assign trigger = bus.sample_valid && (bus.trig_hit || auto_fire);

    // Next-state and capture bookkeeping; abort overrides everything else.
    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        post_d      = post_q;
        cnt_d       = cnt_q;
        trig_addr_d = trig_addr_q;
        auto_trig_d = auto_trig_q;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.arm) begin
                        pre_d   = bus.pre_count;
                        post_d  = DEPTH_C - {1'b0, bus.pre_count};
                        cnt_d   = '0;
                        state_d = (bus.pre_count != '0) ? S_PRETRIG : S_WAIT_TRIG;
                    end
                end
                S_PRETRIG: begin
                    if (bus.sample_valid) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == {1'b0, pre_q}) begin
                            state_d = S_WAIT_TRIG;
                        end
                    end
                end
                S_WAIT_TRIG: begin
                    // Trigger sample is itself written and is post sample number 1.
                    if (trigger) begin
                        trig_addr_d = wr_addr_q;
                        auto_trig_d = !bus.trig_hit;
                        cnt_d       = ONE_C;
                        state_d     = (post_q == ONE_C) ? S_DONE : S_POSTTRIG;
                    end
                end
                S_POSTTRIG: begin
                    if (bus.sample_valid) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == post_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.readout_done) begin
                        cnt_d = '0;
                        if (bus.single_mode) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = (pre_q != '0) ? S_PRETRIG : S_WAIT_TRIG;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Circular write pointer advances on every write, including one in an abort cycle; never cleared by re-arm.
    always_comb begin
        wr_addr_d      = wr_en ? (wr_addr_q + 1'b1) : wr_addr_q;
        state_change_d = (state_d != state_q);
    end

    // State, strobe and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            state_change_q <= 1'b0;
            wr_addr_q      <= '0;
            trig_addr_q    <= '0;
            auto_trig_q    <= 1'b0;
            pre_q          <= '0;
            post_q         <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            state_change_q <= state_change_d;
            wr_addr_q      <= wr_addr_d;
            trig_addr_q    <= trig_addr_d;
            auto_trig_q    <= auto_trig_d;
            pre_q          <= pre_d;
            post_q         <= post_d;
            cnt_q          <= cnt_d;
        end
    end

    assign bus.wr_en        = wr_en;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.trig_addr    = trig_addr_q;
    assign bus.capture_done = (state_q == S_DONE);
    assign bus.auto_trig    = auto_trig_q;
    assign bus.state        = state_q;
    assign bus.state_change = state_change_q;
endmodule

// File: tb/tb_acq_state_ctrl.sv
// Directed bench for acq_state_ctrl with ADDR_W=4 (DEPTH=16) and AUTO_TIMEOUT=20.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Samples seen in WAIT_TRIG before the trigger are written, so a record's write count is pre + waits + post.
module tb_acq_state_ctrl;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   wr_cnt;
    int   w0;

    acq_state_ctrl_if #(.ADDR_W(4)) bus ();

    acq_state_ctrl #(.ADDR_W(4), .AUTO_TIMEOUT(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bus.wr_en) wr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; wr_cnt = 0; w0 = 0;
        rst_n = 1'b0;
        bus.arm = 1'b0; bus.abort = 1'b0; bus.single_mode = 1'b0; bus.pre_count = 4'd0;
        bus.sample_valid = 1'b1; bus.trig_hit = 1'b0; bus.readout_done = 1'b0;
        #12;
        chk("rst_state", bus.state, 8'h00);
        chk("rst_change", bus.state_change, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_trig_addr", bus.trig_addr, 0);
        chk("rst_done", bus.capture_done, 0);
        chk("rst_auto", bus.auto_trig, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        bus.sample_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Record 1: pre=4, trigger on the 7th sample.
        bus.pre_count = 4'd4; bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        chk("r1_pretrig", bus.state, 8'h01);
        chk("r1_pretrig_chg", bus.state_change, 1);
        w0 = wr_cnt;
        bus.sample_valid = 1'b1;
        repeat (3) tick();
        chk("r1_pretrig_hold", bus.state, 8'h01);
        chk("r1_pretrig_chg0", bus.state_change, 0);
        tick();
        chk("r1_wait", bus.state, 8'h02);
        chk("r1_wait_chg", bus.state_change, 1);
        chk("r1_wait_addr", bus.wr_addr, 4);
        tick(); tick();
        chk("r1_wait_hold", bus.state, 8'h02);
        chk("r1_wait_chg0", bus.state_change, 0);
        bus.trig_hit = 1'b1;
        tick();
        bus.trig_hit = 1'b0;
        chk("r1_post", bus.state, 8'h03);
        chk("r1_post_chg", bus.state_change, 1);
        chk("r1_trig_addr", bus.trig_addr, 6);
        chk("r1_post_addr", bus.wr_addr, 7);
        repeat (10) tick();
        chk("r1_post_hold", bus.state, 8'h03);
        tick();
        chk("r1_done", bus.state, 8'h04);
        chk("r1_done_chg", bus.state_change, 1);
        chk("r1_capture_done", bus.capture_done, 1);
        chk("r1_end_addr", bus.wr_addr, 2);
        chk("r1_writes", wr_cnt - w0, 18);
        chk("r1_done_no_wr", bus.wr_en, 0);
        tick();
        chk("r1_done_hold", bus.state, 8'h04);
        chk("r1_done_chg0", bus.state_change, 0);
        chk("r1_done_addr_hold", bus.wr_addr, 2);
        bus.sample_valid = 1'b0;

        // Continuous mode re-arm, then abort mid-POSTTRIG with competing inputs.
        bus.readout_done = 1'b1;
        tick();
        bus.readout_done = 1'b0;
        chk("r2_rearm", bus.state, 8'h01);
        chk("r2_rearm_chg", bus.state_change, 1);
        chk("r2_done_clr", bus.capture_done, 0);
        chk("r2_addr_cont", bus.wr_addr, 2);
        bus.sample_valid = 1'b1;
        repeat (4) tick();
        chk("r2_wait", bus.state, 8'h02);
        chk("r2_wait_addr", bus.wr_addr, 6);
        bus.trig_hit = 1'b1;
        tick();
        bus.trig_hit = 1'b0;
        chk("r2_post", bus.state, 8'h03);
        chk("r2_trig_addr", bus.trig_addr, 6);
        repeat (2) tick();
        bus.abort = 1'b1; bus.trig_hit = 1'b1; bus.readout_done = 1'b1;
        #1;
        chk("r2_abort_wr_en", bus.wr_en, 1);
        tick();
        bus.abort = 1'b0; bus.trig_hit = 1'b0; bus.readout_done = 1'b0; bus.sample_valid = 1'b0;
        chk("r2_abort_idle", bus.state, 8'h00);
        chk("r2_abort_chg", bus.state_change, 1);
        chk("r2_abort_done", bus.capture_done, 0);
        chk("r2_abort_addr", bus.wr_addr, 10);
        chk("r2_abort_trig", bus.trig_addr, 6);

        // pre=0 goes straight to WAIT_TRIG; trig_hit without a sample is ignored; timeout behaviour.
        bus.pre_count = 4'd0; bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        chk("r3_wait", bus.state, 8'h02);
        chk("r3_wait_chg", bus.state_change, 1);
        bus.trig_hit = 1'b1;
        tick();
        bus.trig_hit = 1'b0;
        chk("r3_trig_no_sample", bus.state, 8'h02);
        chk("r3_chg0", bus.state_change, 0);
        repeat (24) tick();
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
`ifdef AUTO_TRIG_EN
        chk("r3_auto_state", bus.state, 8'h03);
        chk("r3_auto_flag", bus.auto_trig, 1);
        chk("r3_auto_trig_addr", bus.trig_addr, 10);
`else
        chk("r3_stay_wait", bus.state, 8'h02);
        chk("r3_auto_flag", bus.auto_trig, 0);
        chk("r3_trig_addr", bus.trig_addr, 6);
`endif
        chk("r3_addr", bus.wr_addr, 11);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("r3_abort_idle", bus.state, 8'h00);

        // pre=15 -> post=1: WAIT_TRIG goes straight to DONE.
        bus.pre_count = 4'd15; bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        chk("r4_pretrig", bus.state, 8'h01);
        w0 = wr_cnt;
        bus.sample_valid = 1'b1;
        repeat (14) tick();
        chk("r4_pretrig_hold", bus.state, 8'h01);
        tick();
        chk("r4_wait", bus.state, 8'h02);
        chk("r4_wait_addr", bus.wr_addr, 10);
        bus.trig_hit = 1'b1;
        tick();
        bus.trig_hit = 1'b0; bus.sample_valid = 1'b0;
        chk("r4_done_direct", bus.state, 8'h04);
        chk("r4_done_chg", bus.state_change, 1);
        chk("r4_trig_addr", bus.trig_addr, 10);
        chk("r4_end_addr", bus.wr_addr, 11);
        chk("r4_writes", wr_cnt - w0, 16);
        chk("r4_real_trig_flag", bus.auto_trig, 0);
        bus.single_mode = 1'b1; bus.arm = 1'b1; bus.sample_valid = 1'b1;
        tick();
        bus.arm = 1'b0; bus.sample_valid = 1'b0;
        chk("r4_arm_ignored", bus.state, 8'h04);
        chk("r4_arm_ignored_chg", bus.state_change, 0);
        chk("r4_no_write_done", bus.wr_addr, 11);
        bus.readout_done = 1'b1;
        tick();
        bus.readout_done = 1'b0;
        chk("r4_single_idle", bus.state, 8'h00);
        chk("r4_single_chg", bus.state_change, 1);
        chk("r4_single_done_clr", bus.capture_done, 0);

        // Asynchronous reset in the middle of a capture.
        bus.single_mode = 1'b0; bus.pre_count = 4'd2; bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0; bus.sample_valid = 1'b1;
        tick();
        chk("r5_mid_capture", bus.wr_addr, 12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r5_async_state", bus.state, 8'h00);
        chk("r5_async_addr", bus.wr_addr, 0);
        chk("r5_async_trig", bus.trig_addr, 0);
        chk("r5_async_chg", bus.state_change, 0);
        chk("r5_async_wr_en", bus.wr_en, 0);
        chk("r5_async_done", bus.capture_done, 0);
        bus.sample_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
